// File: rtl/half_adder_pkg.sv
// Shared defaults and the per-lane half-adder function for half_adder_pipe.
package half_adder_pkg;

  localparam int HA_WIDTH = 1;
  localparam int HA_CNT_W = 16;

  function automatic logic [1:0] ha_calc(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One combinational half-adder lane: (a,b) -> (sum,carry).
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);

  assign {o_carry, o_sum} = ha_calc(i_a, i_b);

endmodule

// File: rtl/half_adder_pipe.sv
// Registered lane-parallel half adder with a one-deep valid/ready stage.
// Optional saturating carry-event counter enabled by the HALF_ADDER_CNT_EN macro.
module half_adder_pipe
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH,
  parameter int CNT_W = HA_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  input  logic             out_ready
`ifdef HALF_ADDER_CNT_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  if (WIDTH < 1) begin : g_width_invalid
    $error("half_adder_pipe: WIDTH must be >= 1");
  end
  if (CNT_W < 1) begin : g_cnt_w_invalid
    $error("half_adder_pipe: CNT_W must be >= 1");
  end

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;
  logic             w_in_ready;
  logic             w_load;
  logic             w_drain;

  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_carry;
  logic             r_out_valid;

  // Operands are masked with in_valid so undriven inputs never reach the cells.
  assign w_a = a & {WIDTH{in_valid}};
  assign w_b = b & {WIDTH{in_valid}};

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    half_adder_cell u_cell (
      .i_a    (w_a[g]),
      .i_b    (w_b[g]),
      .o_sum  (w_sum[g]),
      .o_carry(w_carry[g])
    );
  end

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_load     = in_valid && w_in_ready;
  assign w_drain    = r_out_valid && out_ready;

  // Output stage: load on accept, clear valid on drain-without-load, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_carry     <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_sum       <= w_sum;
      r_carry     <= w_carry;
      r_out_valid <= 1'b1;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign out_valid = r_out_valid;

`ifdef HALF_ADDER_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  // Count outgoing transfers that carry any set bit, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_drain && (r_carry != '0) && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign carry_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_half_adder_pipe.sv
// Randomized self-checking bench for half_adder_pipe (WIDTH=8 and WIDTH=1 instances,
// CNT_W=2); counter checks are active when HALF_ADDER_CNT_EN is defined.
module tb_half_adder_pipe;

  localparam int W  = 8;
  localparam int CW = 2;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic [W-1:0] carry;
  logic         out_valid;
  logic         in_ready;
  logic [0:0]   sum1;
  logic [0:0]   carry1;
  logic         out_valid1;
  logic         in_ready1;
`ifdef HALF_ADDER_CNT_EN
  logic [CW-1:0] carry_cnt;
  logic [CW-1:0] carry_cnt1;
`endif

  always #5 clk = ~clk;

  half_adder_pipe #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .carry(carry), .out_valid(out_valid), .out_ready(out_ready)
`ifdef HALF_ADDER_CNT_EN
    , .carry_cnt(carry_cnt)
`endif
  );

  half_adder_pipe #(.WIDTH(1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a[0:0]), .b(b[0:0]), .in_valid(in_valid), .in_ready(in_ready1),
    .sum(sum1), .carry(carry1), .out_valid(out_valid1), .out_ready(out_ready)
`ifdef HALF_ADDER_CNT_EN
    , .carry_cnt(carry_cnt1)
`endif
  );

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] c;
  } res_t;

  res_t q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  int   exp_cnt1 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    check("out_valid1", {31'd0, out_valid1}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      check("sum", {24'd0, sum}, {24'd0, q[0].s});
      check("carry", {24'd0, carry}, {24'd0, q[0].c});
      check("sum1", {31'd0, sum1}, {31'd0, q[0].s[0]});
      check("carry1", {31'd0, carry1}, {31'd0, q[0].c[0]});
    end
`ifdef HALF_ADDER_CNT_EN
    check("carry_cnt", {30'd0, carry_cnt}, exp_cnt);
    check("carry_cnt1", {30'd0, carry_cnt1}, exp_cnt1);
`endif
  endtask

  // One clock of stimulus; called about 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic rdy);
    logic fire_in;
    logic fire_out;
    in_valid  = v;
    out_ready = rdy;
    a = v ? x : {W{1'bx}};
    b = v ? y : {W{1'bx}};
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, (q.size() == 0) || rdy});
    check("in_ready1", {31'd0, in_ready1}, {31'd0, (q.size() == 0) || rdy});
    fire_out = (q.size() != 0) && rdy;
    fire_in  = v && ((q.size() == 0) || rdy);
    @(posedge clk);
    #1;
    if (fire_out) begin
      if (q[0].c != 0 && exp_cnt < CNT_SAT) exp_cnt++;
      if (q[0].c[0] && exp_cnt1 < CNT_SAT) exp_cnt1++;
      void'(q.pop_front());
    end
    if (fire_in) q.push_back('{s: x ^ y, c: x & y});
    check_outputs();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sum"}, {24'd0, sum}, 32'd0);
    check({tag, "_carry"}, {24'd0, carry}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_sum1"}, {31'd0, sum1}, 32'd0);
`ifdef HALF_ADDER_CNT_EN
    check({tag, "_cnt"}, {30'd0, carry_cnt}, 32'd0);
`endif
  endtask

  logic [1:0] tt_a [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
  logic [1:0] tt_b [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
  logic [1:0] tt_cs[4] = '{2'b00, 2'b01, 2'b01, 2'b10};
  int         sat_want[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // WIDTH=1 truth table, one cycle after acceptance
    for (int i = 0; i < 4; i++) begin
      step(1'b1, {7'd0, tt_a[i][0]}, {7'd0, tt_b[i][0]}, 1'b1);
      check("tt_cs", {30'd0, carry1, sum1}, {30'd0, tt_cs[i]});
    end

    step(1'b1, 8'hF0, 8'h3C, 1'b1);
    check("f0_3c_sum", {24'd0, sum}, 32'h0000_00CC);
    check("f0_3c_carry", {24'd0, carry}, 32'h0000_0030);

    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), $urandom_range(0, 3) != 0);
    end

    // Backpressure: hold a carry=1,sum=0 result while inputs toggle
    step(1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b1, 8'h01, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, W'($urandom), W'($urandom), 1'b0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold", {16'd0, carry, sum}, 32'h0000_0100);
    end
    step(1'b1, 8'h02, 8'h03, 1'b1);
    check("bp_reload", {16'd0, carry, sum}, 32'h0000_0201);

    // Asynchronous reset with a stalled result in flight
    step(1'b1, 8'hFF, 8'hFF, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    q.delete();
    exp_cnt = 0;
    exp_cnt1 = 0;
    @(posedge clk);
    #1;
    check_zero("rst_held");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counter saturation; zero-carry transfers are interleaved
    step(1'b1, 8'h00, 8'h00, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'h80, 8'h80, 1'b1);
      step(1'b1, 8'h00, 8'h11, 1'b1);
`ifdef HALF_ADDER_CNT_EN
      check("cnt_sat", {30'd0, carry_cnt}, sat_want[k]);
`endif
    end

    // Continuous streaming without bubbles
    step(1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, W'($urandom), W'($urandom), 1'b1);
      check("stream_valid", {31'd0, out_valid}, 32'd1);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    check("stream_drained", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
